// File: rtl/dcollide_pair_scheduler_if.sv
// Issue/result/hit ports between the pair scheduler, the collision pipeline and the hit consumer.
// master = scheduler side; slave = pipeline model plus hit consumer side.
interface dcollide_pair_scheduler_if #(
    parameter int IDX_W = 3
);
    logic                 pipe_valid;
    logic [127:0]         pipe_s1;
    logic [127:0]         pipe_s2;
    logic [2*IDX_W-1:0]   pipe_tag;
    logic                 pipe_res_valid;
    logic                 pipe_res_hit;
    logic [2*IDX_W-1:0]   pipe_res_tag;
    logic                 hit_valid;
    logic [IDX_W-1:0]     hit_i;
    logic [IDX_W-1:0]     hit_j;
    logic                 hit_ready;

    modport master (
        output pipe_valid, pipe_s1, pipe_s2, pipe_tag, hit_valid, hit_i, hit_j,
        input  pipe_res_valid, pipe_res_hit, pipe_res_tag, hit_ready
    );

    modport slave (
        input  pipe_valid, pipe_s1, pipe_s2, pipe_tag, hit_valid, hit_i, hit_j,
        output pipe_res_valid, pipe_res_hit, pipe_res_tag, hit_ready
    );
endinterface

// File: rtl/dcollide_pair_scheduler.sv
// Walks all unordered sphere pairs (i<j), issues them to the collision pipeline under hit-FIFO credits,
// and queues colliding pairs for the consumer. Optional DCOLLIDE_SCHED_PERF_EN adds run/stall cycle counters.
module dcollide_pair_scheduler #(
    parameter int N_SPHERES      = 8,
    parameter int IDX_W          = 3,
    parameter int PIPE_LAT       = 5,
    parameter int HIT_FIFO_DEPTH = 4
) (
    input  logic               CLOCK_50,
    input  logic               key0,
    input  logic               start,
    input  logic [IDX_W:0]     num_spheres,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   mem_addr,
    input  logic [127:0]       mem_rdata,
    output logic [15:0]        pair_count,
    output logic [15:0]        hit_count,
`ifdef DCOLLIDE_SCHED_PERF_EN
    output logic [31:0]        run_cycles,
    output logic [31:0]        stall_cycles,
`endif
    dcollide_pair_scheduler_if.master bus
);
    localparam int PTR_W = (HIT_FIFO_DEPTH > 1) ? $clog2(HIT_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(HIT_FIFO_DEPTH + 1);
    localparam int FL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int TAG_W = 2 * IDX_W;

    typedef enum logic [2:0] {FLUSH, IDLE, FETCH_I, STREAM, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [IDX_W-1:0] i_idx, j_idx, i_n, j_n;
    logic [IDX_W:0]   num_r;
    logic [127:0]     s_i;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] inflight, fifo_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [TAG_W-1:0] fifo_mem [HIT_FIFO_DEPTH];
    logic             issue, latch_si, credit_ok, ret, push, pop, run_start;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Credits cover both in-flight pairs and queued hits so every possible hit has a FIFO slot.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(HIT_FIFO_DEPTH);
    assign ret       = bus.pipe_res_valid && (state != FLUSH);
    assign push      = ret && bus.pipe_res_hit;
    assign pop       = bus.hit_valid && bus.hit_ready;
    assign run_start = (state == IDLE) && start;
    assign busy      = (state == FETCH_I) || (state == STREAM) || (state == DRAIN) || (state == DONE);
    assign done      = (state == DONE);

    assign bus.hit_valid = (fifo_count != '0);
    assign bus.hit_i     = bus.hit_valid ? fifo_mem[rd_ptr][TAG_W-1:IDX_W] : '0;
    assign bus.hit_j     = bus.hit_valid ? fifo_mem[rd_ptr][IDX_W-1:0]     : '0;

    always_comb begin
        state_n  = state;
        i_n      = i_idx;
        j_n      = j_idx;
        mem_addr = '0;
        issue    = 1'b0;
        latch_si = 1'b0;
        case (state)
            FLUSH: begin
                if (flush_cnt == FL_W'(PIPE_LAT - 1)) state_n = IDLE;
            end
            IDLE: begin
                if (start) begin
                    if (num_spheres < (IDX_W+1)'(2)) begin
                        state_n = DONE;
                    end else begin
                        i_n     = '0;
                        j_n     = IDX_W'(1);
                        state_n = FETCH_I;
                    end
                end
            end
            FETCH_I: begin
                latch_si = 1'b1;
                mem_addr = j_idx;
                state_n  = STREAM;
            end
            STREAM: begin
                mem_addr = j_idx;
                if (credit_ok) begin
                    issue = 1'b1;
                    if ({1'b0, j_idx} < num_r - (IDX_W+1)'(1)) begin
                        j_n      = j_idx + IDX_W'(1);
                        mem_addr = j_idx + IDX_W'(1);
                    end else if ({1'b0, i_idx} < num_r - (IDX_W+1)'(2)) begin
                        i_n      = i_idx + IDX_W'(1);
                        j_n      = i_idx + IDX_W'(2);
                        mem_addr = i_idx + IDX_W'(1);
                        state_n  = FETCH_I;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifo_count == '0) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = FLUSH;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!key0) begin
            state          <= FLUSH;
            flush_cnt      <= '0;
            i_idx          <= '0;
            j_idx          <= '0;
            num_r          <= '0;
            inflight       <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pair_count     <= '0;
            hit_count      <= '0;
            bus.pipe_valid <= 1'b0;
            bus.pipe_s1    <= '0;
            bus.pipe_s2    <= '0;
            bus.pipe_tag   <= '0;
        end else begin
            state     <= state_n;
            i_idx     <= i_n;
            j_idx     <= j_n;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;
            if (run_start) begin
                num_r      <= num_spheres;
                pair_count <= '0;
                hit_count  <= '0;
            end else begin
                if (issue) pair_count <= sat_inc16(pair_count);
                if (push)  hit_count  <= sat_inc16(hit_count);
            end
            case ({issue, ret})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Issue stage: s1 comes from the latched row sphere, s2 straight from the memory read.
            bus.pipe_valid <= issue;
            if (issue) begin
                bus.pipe_s1  <= s_i;
                bus.pipe_s2  <= mem_rdata;
                bus.pipe_tag <= {i_idx, j_idx};
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (latch_si) s_i <= mem_rdata;
        if (push)     fifo_mem[wr_ptr] <= bus.pipe_res_tag;
    end

    always_ff @(posedge CLOCK_50) begin
        if (key0) begin
            assert (!(push && !pop && fifo_count == CNT_W'(HIT_FIFO_DEPTH)));
            assert (!run_start || num_spheres <= (IDX_W+1)'(N_SPHERES));
        end
    end

`ifdef DCOLLIDE_SCHED_PERF_EN
    always_ff @(posedge CLOCK_50) begin
        if (!key0 || run_start) begin
            run_cycles   <= '0;
            stall_cycles <= '0;
        end else begin
            if (busy) run_cycles <= run_cycles + 32'd1;
            if (state == STREAM && !credit_ok) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcollide_pair_scheduler.sv
// Directed bench for dcollide_pair_scheduler: sphere memory and fixed-latency pipeline models,
// a table of whole-run vectors, and hand sequences for credit stall, abort and re-start.
module tb_dcollide_pair_scheduler;
    localparam int IDX_W    = 3;
    localparam int PIPE_LAT = 5;

    logic         clk = 1'b0;
    logic         key0;
    logic         start;
    logic [3:0]   num_spheres;
    logic         busy, done;
    logic [2:0]   mem_addr;
    logic [127:0] mem_rdata;
    logic [15:0]  pair_count, hit_count;
`ifdef DCOLLIDE_SCHED_PERF_EN
    logic [31:0]  run_cycles, stall_cycles;
`endif

    dcollide_pair_scheduler_if #(.IDX_W(IDX_W)) bus ();

    dcollide_pair_scheduler #(.N_SPHERES(8), .IDX_W(IDX_W), .PIPE_LAT(PIPE_LAT), .HIT_FIFO_DEPTH(4)) dut (
        .CLOCK_50    (clk),
        .key0        (key0),
        .start       (start),
        .num_spheres (num_spheres),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pair_count  (pair_count),
        .hit_count   (hit_count),
`ifdef DCOLLIDE_SCHED_PERF_EN
        .run_cycles  (run_cycles),
        .stall_cycles(stall_cycles),
`endif
        .bus         (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // 0: every pair hits, 1: only neighbours (j==i+1) hit, 2: nothing hits
    function automatic logic hitf(input int m, input logic [5:0] t);
        int a, b;
        a = int'(t[5:3]);
        b = int'(t[2:0]);
        case (m)
            0:       return 1'b1;
            1:       return (b == a + 1);
            default: return 1'b0;
        endcase
    endfunction

    logic [127:0] sph [8];
    int hit_mode = 0;
    int rdy_mode = 0;
    int cyc = 0;

    always @(posedge clk) mem_rdata <= sph[mem_addr];

    logic [4:0] dv = '0;
    logic [5:0] dt [5];
    always @(posedge clk) begin
        dv    <= {dv[3:0], bus.pipe_valid};
        dt[0] <= bus.pipe_tag;
        for (int k = 1; k < 5; k++) dt[k] <= dt[k-1];
    end
    assign bus.pipe_res_valid = dv[4];
    assign bus.pipe_res_tag   = dt[4];
    assign bus.pipe_res_hit   = hitf(hit_mode, dt[4]);

    always @(posedge clk) begin
        #1;
        cyc++;
        bus.hit_ready = (rdy_mode == 0) || (rdy_mode == 1 && cyc[0]);
    end

    int wi, wj, wnum, issued, popped, done_cnt;
    logic [5:0] hq [$];

    always @(negedge clk) begin
        if (bus.pipe_valid) begin
            chk("pipe_tag", bus.pipe_tag, {wi[2:0], wj[2:0]});
            chk("pipe_s1", bus.pipe_s1, sph[wi[2:0]]);
            chk("pipe_s2", bus.pipe_s2, sph[wj[2:0]]);
            issued++;
            if (wj < wnum - 1) wj++;
            else begin wi++; wj = wi + 1; end
        end
        if (bus.hit_valid && bus.hit_ready) begin
            if (hq.size() == 0) chk("hit_extra", {bus.hit_i, bus.hit_j}, 6'h3f);
            else chk("hit_ij", {bus.hit_i, bus.hit_j}, hq.pop_front());
            popped++;
        end
        if (done) done_cnt++;
    end

    task automatic prep(input int num, input int mode);
        hit_mode = mode;
        wi = 0; wj = 1; wnum = num;
        issued = 0; popped = 0; done_cnt = 0;
        hq.delete();
        for (int a = 0; a < num; a++)
            for (int b = a + 1; b < num; b++)
                if (hitf(mode, {a[2:0], b[2:0]})) hq.push_back({a[2:0], b[2:0]});
    endtask

    task automatic pulse_start(input int num);
        @(negedge clk);
        start = 1'b1;
        num_spheres = num[3:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int budget, output int t);
        t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic final_checks(input int ep, input int eh);
        repeat (3) @(negedge clk);
        chk("pair_count", pair_count, ep);
        chk("hit_count", hit_count, eh);
        chk("issued", issued, ep);
        chk("popped", popped, eh);
        chk("hits_left", hq.size(), 0);
        chk("done_pulses", done_cnt, 1);
        chk("busy_idle", busy, 1'b0);
        chk("hit_valid_idle", bus.hit_valid, 1'b0);
    endtask

    typedef struct { int num; int mode; int rdy; int pairs; int hits; } vec_t;
    vec_t tbl [8];

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout actual=%0d required=finish", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        tbl[0] = '{num: 4, mode: 0, rdy: 0, pairs: 6,  hits: 6};
        tbl[1] = '{num: 8, mode: 1, rdy: 0, pairs: 28, hits: 7};
        tbl[2] = '{num: 8, mode: 2, rdy: 0, pairs: 28, hits: 0};
        tbl[3] = '{num: 3, mode: 1, rdy: 1, pairs: 3,  hits: 2};
        tbl[4] = '{num: 5, mode: 0, rdy: 1, pairs: 10, hits: 10};
        tbl[5] = '{num: 1, mode: 0, rdy: 0, pairs: 0,  hits: 0};
        tbl[6] = '{num: 0, mode: 0, rdy: 0, pairs: 0,  hits: 0};
        tbl[7] = '{num: 6, mode: 0, rdy: 1, pairs: 15, hits: 15};

        for (int k = 0; k < 8; k++)
            sph[k] = {32'h40000000 + k, 32'h41000000 + k, 32'h42000000 + 3 * k, 32'h3F000000 + k};
        sph[0] = {32'hBEFC432D, 32'h00000000, 32'h3FC00000, 32'h3F000000};
        sph[1] = {32'h3EFC432D, 32'h00000000, 32'h3FC00000, 32'h3F000000};

        key0 = 1'b0; start = 1'b0; num_spheres = '0;
        prep(0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pipe_valid", bus.pipe_valid, 1'b0);
        chk("rst_hit_valid", bus.hit_valid, 1'b0);
        chk("rst_pair_count", pair_count, 16'd0);
        chk("rst_hit_count", hit_count, 16'd0);
        chk("rst_mem_addr", mem_addr, 3'd0);
        key0 = 1'b1;
        start = 1'b1; num_spheres = 4'd8;
        @(negedge clk);
        start = 1'b0;
        chk("flush_start_ignored", busy, 1'b0);
        repeat (6) @(negedge clk);

        // Two-sphere run with first-issue latency
        prep(2, 0);
        rdy_mode = 0;
        pulse_start(2);
        chk("lat_fetch", bus.pipe_valid, 1'b0);
        @(negedge clk);
        chk("lat_stream", bus.pipe_valid, 1'b0);
        @(negedge clk);
        chk("lat_first_issue", bus.pipe_valid, 1'b1);
        wait_done(200, t);
        final_checks(1, 1);

        for (int v = 0; v < 8; v++) begin
            prep(tbl[v].num, tbl[v].mode);
            rdy_mode = tbl[v].rdy;
            pulse_start(tbl[v].num);
            wait_done(3000, t);
            if (tbl[v].num < 2) chk("done_latency", t, 0);
            final_checks(tbl[v].pairs, tbl[v].hits);
        end

        // Consumer stalled: issue must stop at the credit limit
        prep(8, 0);
        rdy_mode = 2;
        pulse_start(8);
        repeat (50) @(negedge clk);
        chk("stall_issued", issued, 4);
        chk("stall_hit_valid", bus.hit_valid, 1'b1);
        chk("stall_pipe_valid", bus.pipe_valid, 1'b0);
        chk("stall_pair_count", pair_count, 16'd4);
        rdy_mode = 0;
        wait_done(3000, t);
        final_checks(28, 28);

        // Abort mid-stream, start ignored during flush, stale results dropped
        prep(8, 0);
        pulse_start(8);
        repeat (6) @(negedge clk);
        key0 = 1'b0;
        @(negedge clk);
        key0 = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hit_valid", bus.hit_valid, 1'b0);
        chk("abort_pipe_valid", bus.pipe_valid, 1'b0);
        chk("abort_pair_count", pair_count, 16'd0);
        start = 1'b1; num_spheres = 4'd8;
        @(negedge clk);
        start = 1'b0;
        chk("abort_start_ignored", busy, 1'b0);
        repeat (7) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stale_dropped", bus.hit_valid, 1'b0);
        prep(8, 0);
        pulse_start(8);
        wait_done(3000, t);
        final_checks(28, 28);

        // Start re-pulsed while busy must be ignored
        prep(8, 0);
        rdy_mode = 1;
        pulse_start(8);
        repeat (10) @(negedge clk);
        start = 1'b1; num_spheres = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, t);
        final_checks(28, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
